// File: rtl/id_redirect_ctrl_pkg.sv
// Shared opcodes, FSM encoding and decode helpers for the ID-stage redirect controller.
// Optional feature: define BNE_EN to decode bne (6'h05) as a conditional branch.
package id_redirect_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_e;

    typedef struct packed {
        logic rs;
        logic rt;
    } src_use_t;

    function automatic logic is_cond_branch(input logic [5:0] op);
`ifdef BNE_EN
        return (op == OP_BEQ) || (op == OP_BNE);
`else
        return (op == OP_BEQ);
`endif
    endfunction

    // Which source fields of the instruction are actually read.
    function automatic src_use_t decode_src(input logic [5:0] op);
        src_use_t u;
        u = '0;
        case (op)
            OP_RTYPE, OP_SW:                  u = '{rs: 1'b1, rt: 1'b1};
            OP_LW, OP_ADDI, OP_ANDI, OP_ORI,
            OP_SLTI:                          u = '{rs: 1'b1, rt: 1'b0};
            default:                          u = '0;
        endcase
        if (is_cond_branch(op)) begin
            u = '{rs: 1'b1, rt: 1'b1};
        end
        return u;
    endfunction

endpackage

// File: rtl/id_hazard_detect.sv
// Combinational load-use and branch-operand hazard compare for the instruction held in IF/ID.
// Optional feature: BNE_EN (via the package) makes bne subject to branch-operand hazards.
module id_hazard_detect
    import id_redirect_ctrl_pkg::*;
(
    input  logic [5:0] op_i,
    input  logic [4:0] rs_i,
    input  logic [4:0] rt_i,
    input  logic       ex_mem_read_i,
    input  logic       ex_reg_write_i,
    input  logic [4:0] ex_dst_i,
    input  logic       mem_mem_read_i,
    input  logic [4:0] mem_dst_i,
    output logic       hazard_o
);

    src_use_t uses;
    logic     rs_live;
    logic     rt_live;
    logic     ex_match;
    logic     mem_match;
    logic     load_use;
    logic     br_hazard;

    always_comb begin
        uses      = decode_src(op_i);
        // $0 is hardwired, so it can never carry a dependency.
        rs_live   = uses.rs && (rs_i != 5'd0);
        rt_live   = uses.rt && (rt_i != 5'd0);
        ex_match  = (rs_live && (ex_dst_i == rs_i)) || (rt_live && (ex_dst_i == rt_i));
        mem_match = (rs_live && (mem_dst_i == rs_i)) || (rt_live && (mem_dst_i == rt_i));
        load_use  = ex_mem_read_i && ex_match;
        br_hazard = is_cond_branch(op_i) &&
                    ((ex_reg_write_i && ex_match) || (mem_mem_read_i && mem_match));
        hazard_o  = load_use || br_hazard;
    end

endmodule

// File: rtl/id_redirect_ctrl.sv
// ID-stage controller: IF/ID register, beq/j resolution, fetch redirect and hazard stall.
// Optional feature: define BNE_EN to resolve bne (taken when operands differ).
module id_redirect_ctrl
    import id_redirect_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      nextInstAdr,
    input  logic [31:0]      Inst,
    input  logic [31:0]      rfRd1,
    input  logic [31:0]      rfRd2,
    input  logic             exMemRead,
    input  logic             exRegWrite,
    input  logic [4:0]       exDst,
    input  logic             memMemRead,
    input  logic [4:0]       memDst,
    output logic             pcWrite,
    output logic             flush,
    output logic             PcSrc,
    output logic             jmp,
    output logic [31:0]      beqAdr,
    output logic [25:0]      jmpAdr,
    output logic [31:0]      ifIdInst,
    output logic [31:0]      ifIdPc4,
    output logic             idBubble,
    output logic [CNT_W-1:0] stallCnt,
    output logic [CNT_W-1:0] redirCnt,
    output logic             stallState
);

    logic [31:0]      if_id_inst_q;
    logic [31:0]      if_id_pc4_q;
    state_e           state_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] redir_cnt_q;

    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [15:0] imm;
    logic        hazard;
    logic        br_taken;
    logic        redirect;

    assign opcode = if_id_inst_q[31:26];
    assign rs     = if_id_inst_q[25:21];
    assign rt     = if_id_inst_q[20:16];
    assign imm    = if_id_inst_q[15:0];

    id_hazard_detect u_hazard (
        .op_i           (opcode),
        .rs_i           (rs),
        .rt_i           (rt),
        .ex_mem_read_i  (exMemRead),
        .ex_reg_write_i (exRegWrite),
        .ex_dst_i       (exDst),
        .mem_mem_read_i (memMemRead),
        .mem_dst_i      (memDst),
        .hazard_o       (hazard)
    );

    always_comb begin
        br_taken = (opcode == OP_BEQ) && (rfRd1 == rfRd2);
`ifdef BNE_EN
        br_taken = br_taken || ((opcode == OP_BNE) && (rfRd1 != rfRd2));
`endif
        // A stall suppresses any redirect; the branch re-resolves once operands are ready.
        pcWrite  = !hazard;
        idBubble = hazard;
        PcSrc    = !hazard && br_taken;
        jmp      = !hazard && (opcode == OP_J);
        redirect = PcSrc || jmp;
        flush    = redirect;
        beqAdr   = if_id_pc4_q + {{14{imm[15]}}, imm, 2'b00};
        jmpAdr   = if_id_inst_q[25:0];
    end

    assign ifIdInst   = if_id_inst_q;
    assign ifIdPc4    = if_id_pc4_q;
    assign stallCnt   = stall_cnt_q;
    assign redirCnt   = redir_cnt_q;
    assign stallState = (state_q == STALL);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_id_inst_q <= 32'd0;
            if_id_pc4_q  <= 32'd0;
            state_q      <= RUN;
            stall_cnt_q  <= '0;
            redir_cnt_q  <= '0;
        end else begin
            state_q <= hazard ? STALL : RUN;
            if (!hazard) begin
                if_id_inst_q <= Inst;
                if_id_pc4_q  <= nextInstAdr;
            end
            if (hazard && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (redirect && (redir_cnt_q != {CNT_W{1'b1}})) begin
                redir_cnt_q <= redir_cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_id_redirect_ctrl.sv
// Directed self-checking bench for id_redirect_ctrl; expected values are hand-computed constants.
module tb_id_redirect_ctrl;

    localparam int unsigned CNT_W = 4;

    logic             clk;
    logic             rst;
    logic [31:0]      nextInstAdr;
    logic [31:0]      Inst;
    logic [31:0]      rfRd1;
    logic [31:0]      rfRd2;
    logic             exMemRead;
    logic             exRegWrite;
    logic [4:0]       exDst;
    logic             memMemRead;
    logic [4:0]       memDst;
    logic             pcWrite;
    logic             flush;
    logic             PcSrc;
    logic             jmp;
    logic [31:0]      beqAdr;
    logic [25:0]      jmpAdr;
    logic [31:0]      ifIdInst;
    logic [31:0]      ifIdPc4;
    logic             idBubble;
    logic [CNT_W-1:0] stallCnt;
    logic [CNT_W-1:0] redirCnt;
    logic             stallState;

    int n_checks = 0;
    int n_pass   = 0;

    localparam logic [31:0] I_ADD   = 32'h0044_1820; // add $3,$2,$4
    localparam logic [31:0] I_ADDI  = 32'h2003_0005; // addi $3,$0,5
    localparam logic [31:0] I_BEQ   = 32'h1022_FFFF; // beq $1,$2,-1
    localparam logic [31:0] I_J     = 32'h0800_0040; // j 0x40
    localparam logic [31:0] I_ADDZ  = 32'h0000_2020; // add $4,$0,$0
    localparam logic [31:0] I_BNE   = 32'h1422_0004; // bne $1,$2,+4

    id_redirect_ctrl #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .nextInstAdr (nextInstAdr),
        .Inst        (Inst),
        .rfRd1       (rfRd1),
        .rfRd2       (rfRd2),
        .exMemRead   (exMemRead),
        .exRegWrite  (exRegWrite),
        .exDst       (exDst),
        .memMemRead  (memMemRead),
        .memDst      (memDst),
        .pcWrite     (pcWrite),
        .flush       (flush),
        .PcSrc       (PcSrc),
        .jmp         (jmp),
        .beqAdr      (beqAdr),
        .jmpAdr      (jmpAdr),
        .ifIdInst    (ifIdInst),
        .ifIdPc4     (ifIdPc4),
        .idBubble    (idBubble),
        .stallCnt    (stallCnt),
        .redirCnt    (redirCnt),
        .stallState  (stallState)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; nextInstAdr = 32'h4; Inst = 32'd0; rfRd1 = 32'd0; rfRd2 = 32'd0;
        exMemRead = 1'b0; exRegWrite = 1'b0; exDst = 5'd0; memMemRead = 1'b0; memDst = 5'd0;

        // Reset values
        #2;
        chk("rst_pcWrite", pcWrite, 1);
        chk("rst_flush", flush, 0);
        chk("rst_bubble", idBubble, 0);
        chk("rst_inst", ifIdInst, 0);
        chk("rst_pc4", ifIdPc4, 0);
        chk("rst_stallCnt", stallCnt, 0);
        chk("rst_redirCnt", redirCnt, 0);
        chk("rst_state", stallState, 0);
        #10 rst = 1'b1;
        #1;
        chk("rel_pcWrite", pcWrite, 1);
        chk("rel_PcSrc", PcSrc, 0);
        chk("rel_jmp", jmp, 0);

        // Load-use stall: add reads $2 while lw $2 is in EX
        Inst = I_ADD; nextInstAdr = 32'h8;
        tick();
        chk("lu_load_inst", ifIdInst, I_ADD);
        chk("lu_load_pc4", ifIdPc4, 32'h8);
        exMemRead = 1'b1; exDst = 5'd2; Inst = I_ADDI; nextInstAdr = 32'hC;
        #1;
        chk("lu_pcWrite", pcWrite, 0);
        chk("lu_bubble", idBubble, 1);
        chk("lu_flush", flush, 0);
        tick();
        chk("lu_hold_inst", ifIdInst, I_ADD);
        chk("lu_hold_pc4", ifIdPc4, 32'h8);
        chk("lu_stallCnt", stallCnt, 1);
        chk("lu_state", stallState, 1);
        exMemRead = 1'b0; exDst = 5'd0; memMemRead = 1'b1; memDst = 5'd2;
        Inst = I_BEQ; nextInstAdr = 32'h10;
        #1;
        chk("lu_clear_pcWrite", pcWrite, 1);
        chk("lu_clear_bubble", idBubble, 0);
        tick();
        chk("lu_after_inst", ifIdInst, I_BEQ);
        chk("lu_after_pc4", ifIdPc4, 32'h10);
        chk("lu_after_stallCnt", stallCnt, 1);
        chk("lu_after_state", stallState, 0);

        // beq resolution: not taken, then taken
        memMemRead = 1'b0; memDst = 5'd0; rfRd1 = 32'd5; rfRd2 = 32'd6;
        Inst = 32'd0; nextInstAdr = 32'h14;
        #1;
        chk("beq_nt_PcSrc", PcSrc, 0);
        chk("beq_nt_flush", flush, 0);
        rfRd2 = 32'd5;
        #1;
        chk("beq_PcSrc", PcSrc, 1);
        chk("beq_flush", flush, 1);
        chk("beq_pcWrite", pcWrite, 1);
        chk("beq_jmp", jmp, 0);
        chk("beq_adr", beqAdr, 32'h0000_000C);
        tick();
        chk("beq_next_inst", ifIdInst, 0);
        chk("beq_redirCnt", redirCnt, 1);

        // Jump
        Inst = I_J; nextInstAdr = 32'h18;
        #1;
        chk("nop_flush", flush, 0);
        tick();
        chk("j_inst", ifIdInst, I_J);
        Inst = 32'd0;
        #1;
        chk("j_jmp", jmp, 1);
        chk("j_flush", flush, 1);
        chk("j_PcSrc", PcSrc, 0);
        chk("j_adr", jmpAdr, 32'h40);
        chk("j_pcWrite", pcWrite, 1);
        tick();
        chk("j_next_inst", ifIdInst, 0);
        chk("j_redirCnt", redirCnt, 2);

        // $0 never matches
        Inst = I_ADDZ; nextInstAdr = 32'h1C;
        tick();
        exMemRead = 1'b1; exDst = 5'd0;
        #1;
        chk("zero_pcWrite", pcWrite, 1);
        exMemRead = 1'b0;

        // Branch-operand hazards on beq $1,$2
        Inst = I_BEQ; nextInstAdr = 32'h20;
        tick();
        chk("bh_inst", ifIdInst, I_BEQ);
        memMemRead = 1'b1; memDst = 5'd1; rfRd1 = 32'd7; rfRd2 = 32'd7;
        Inst = 32'd0; nextInstAdr = 32'h24;
        #1;
        chk("bh_mem_pcWrite", pcWrite, 0);
        chk("bh_mem_bubble", idBubble, 1);
        chk("bh_mem_PcSrc", PcSrc, 0);
        chk("bh_mem_flush", flush, 0);
        tick();
        chk("bh_hold_inst", ifIdInst, I_BEQ);
        chk("bh_stallCnt1", stallCnt, 2);
        exRegWrite = 1'b1; exDst = 5'd2;
        #1;
        chk("bh_both_pcWrite", pcWrite, 0);
        tick();
        chk("bh_stallCnt2", stallCnt, 3);
        memMemRead = 1'b0; memDst = 5'd0;
        #1;
        chk("bh_ex_pcWrite", pcWrite, 0);
        tick();
        chk("bh_stallCnt3", stallCnt, 4);
        exRegWrite = 1'b0; exDst = 5'd0;
        #1;
        chk("bh_PcSrc", PcSrc, 1);
        chk("bh_flush", flush, 1);
        chk("bh_adr", beqAdr, 32'h0000_001C);
        tick();
        chk("bh_next_inst", ifIdInst, 0);
        chk("bh_redirCnt", redirCnt, 3);
        chk("bh_stallCnt4", stallCnt, 4);

        // Stall counter saturation: 2^CNT_W + 3 stall cycles
        Inst = I_ADD; nextInstAdr = 32'h28;
        tick();
        exMemRead = 1'b1; exDst = 5'd2;
        repeat ((1 << CNT_W) + 3) tick();
        chk("sat_stallCnt", stallCnt, 32'hF);
        chk("sat_inst", ifIdInst, I_ADD);
        chk("sat_redirCnt", redirCnt, 3);

        // Reset mid-stall
        #2 rst = 1'b0;
        #1;
        chk("mrst_inst", ifIdInst, 0);
        chk("mrst_state", stallState, 0);
        chk("mrst_stallCnt", stallCnt, 0);
        chk("mrst_redirCnt", redirCnt, 0);
        chk("mrst_pcWrite", pcWrite, 1);
        #3 rst = 1'b1;
        exMemRead = 1'b0; exDst = 5'd0;

        // bne $1,$2 with different operands and a pending lw $1 in MEM
        Inst = I_BNE; nextInstAdr = 32'h40;
        tick();
        chk("bne_inst", ifIdInst, I_BNE);
        rfRd1 = 32'd1; rfRd2 = 32'd2; memMemRead = 1'b1; memDst = 5'd1; Inst = 32'd0;
        #1;
`ifdef BNE_EN
        chk("bne_haz_pcWrite", pcWrite, 0);
        memMemRead = 1'b0; memDst = 5'd0;
        #1;
        chk("bne_PcSrc", PcSrc, 1);
        chk("bne_flush", flush, 1);
        chk("bne_adr", beqAdr, 32'h0000_0050);
`else
        chk("bne_off_pcWrite", pcWrite, 1);
        chk("bne_off_PcSrc", PcSrc, 0);
        chk("bne_off_flush", flush, 0);
`endif
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
